// File: rtl/vid_scan_gen.sv
// +----------------------------------------------------------------------------+
// | vid_scan_gen: raster timing, framebuffer addressing, 2x2 doubling, prefetch |
// | Revision 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module vid_scan_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int ADDR_W   = 20,
  parameter int FB_BASE  = 0
) (
  input  logic              clk_int,
  input  logic              rst,
  input  logic              pix_en,
  input  logic              dbl,
  output logic              hs,
  output logic              vs,
  output logic              de,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              frame_start,
  output logic              line_start,
  output logic              fetch_req,
  output logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_ack,
  output logic              underrun
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT + 1);
  localparam int VW    = $clog2(V_TOT + 1);

  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_ACTM = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);

  localparam logic [ADDR_W-1:0] A_BASE = ADDR_W'(FB_BASE);
  localparam logic [ADDR_W-1:0] A_LINE = ADDR_W'(H_ACTIVE);
  localparam logic [ADDR_W-1:0] A_HALF = ADDR_W'(H_ACTIVE / 2);
  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT_LINE = 2'd2} fetch_state_t;

  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  logic              dbl_r;
  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] next_base;
  fetch_state_t      state;

  logic h_wrap, v_wrap, h_act, v_act, frame_pt, need_fetch;

  assign h_wrap   = (h_cnt == H_LAST);
  assign v_wrap   = (v_cnt == V_LAST);
  assign h_act    = (h_cnt < H_ACT);
  assign v_act    = (v_cnt < V_ACT);
  assign frame_pt = (h_cnt == '0) && (v_cnt == '0);

  // In doubled mode only even lines open a new framebuffer row.
  assign need_fetch = (v_wrap || (v_cnt < V_ACTM)) && (!dbl_r || v_wrap || v_cnt[0]);

  // Base address of the line following the current one.
  always_comb begin
    next_base = line_base + A_LINE;
    if (v_wrap)
      next_base = A_BASE;
    else if (dbl_r)
      next_base = v_cnt[0] ? (line_base + A_HALF) : line_base;
  end

  always_ff @(posedge clk_int) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      dbl_r       <= 1'b0;
      line_base   <= A_BASE;
      hs          <= ~HS_ACT;
      vs          <= ~VS_ACT;
      de          <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      pix_addr    <= A_BASE;
    end else if (pix_en) begin
      h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
      if (h_wrap) begin
        v_cnt     <= v_wrap ? '0 : v_cnt + 1'b1;
        line_base <= next_base;
      end
      if (frame_pt)
        dbl_r <= dbl;
      hs          <= (h_cnt >= HS_BEG && h_cnt < HS_END) ? HS_ACT : ~HS_ACT;
      vs          <= (v_cnt >= VS_BEG && v_cnt < VS_END) ? VS_ACT : ~VS_ACT;
      de          <= h_act && v_act;
      frame_start <= frame_pt;
      line_start  <= (h_cnt == '0) && v_act;
      // Doubled mode repeats each address on an odd pixel.
      if (h_act && v_act) begin
        if (h_cnt == '0)
          pix_addr <= line_base;
        else if (!dbl_r || !h_cnt[0])
          pix_addr <= pix_addr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_int) begin
    if (rst) begin
      state      <= IDLE;
      fetch_req  <= 1'b0;
      fetch_addr <= A_BASE;
      underrun   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (h_cnt == H_ACT && need_fetch) begin
            state      <= REQ;
            fetch_req  <= 1'b1;
            fetch_addr <= next_base;
          end
        end
        REQ: begin
          // An ack arriving on the wrap cycle still wins over underrun.
          if (fetch_ack) begin
            state     <= WAIT_LINE;
            fetch_req <= 1'b0;
          end else if (h_cnt == '0) begin
            state     <= IDLE;
            fetch_req <= 1'b0;
            underrun  <= 1'b1;
          end
        end
        WAIT_LINE: begin
          if (h_cnt == '0)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vid_scan_gen.sv
// +----------------------------------------------------------------------------+
// | tb_vid_scan_gen: scoreboard bench for vid_scan_gen on a reduced raster     |
// | Revision 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_vid_scan_gen;

  localparam int HA = 8, HFP = 2, HSW = 3, HBP = 3;
  localparam int VA = 6, VFP = 1, VSW = 2, VBP = 1;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FT = HT * VT;
  localparam int AW = 12;
  localparam int BASE = 256;

  logic clk_int = 1'b0;
  logic rst = 1'b1, pix_en = 1'b1, dbl = 1'b0, fetch_ack = 1'b0, ack_en = 1'b1;
  logic hs, vs, de, frame_start, line_start, fetch_req, underrun;
  logic [AW-1:0] pix_addr, fetch_addr;

  vid_scan_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(0), .VS_POL(0), .ADDR_W(AW), .FB_BASE(BASE)
  ) dut (
    .clk_int(clk_int), .rst(rst), .pix_en(pix_en), .dbl(dbl),
    .hs(hs), .vs(vs), .de(de), .pix_addr(pix_addr),
    .frame_start(frame_start), .line_start(line_start),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .underrun(underrun)
  );

  always #5 clk_int = ~clk_int;

  typedef struct packed {
    logic hs, vs, de, fs, ls, freq, und;
    logic [AW-1:0] addr, faddr;
  } exp_t;

  exp_t exp_q[$];
  exp_t obs, e;
  assign obs = {hs, vs, de, frame_start, line_start, fetch_req, underrun, pix_addr, fetch_addr};

  int total = 0, bad = 0, cyc = 0;

  // Reference model state.
  int mh = 0, mv = 0;
  logic mdbl = 0, mreq = 0, mfired = 0, mund = 0;
  logic mhs = 1, mvs = 1, mde = 0, mfs = 0, mls = 0;
  logic [AW-1:0] maddr = AW'(BASE), mfaddr = AW'(BASE);

  function automatic logic [AW-1:0] ref_addr(int v, int h, logic d);
    int a;
    a = d ? BASE + (v / 2) * (HA / 2) + h / 2 : BASE + v * HA + h;
    return a[AW-1:0];
  endfunction

  task automatic model_step();
    int nv;
    if (rst) begin
      mh = 0; mv = 0; mdbl = 0; mreq = 0; mfired = 0; mund = 0;
      mhs = 1; mvs = 1; mde = 0; mfs = 0; mls = 0;
      maddr = AW'(BASE); mfaddr = AW'(BASE);
    end else begin
      if (mreq) begin
        if (fetch_ack) mreq = 0;
        else if (mh == 0) begin mreq = 0; mund = 1; end
      end else if (mh == HA && !mfired) begin
        nv = (mv == VT - 1) ? 0 : mv + 1;
        if (nv < VA && (!mdbl || (nv % 2) == 0)) begin
          mreq = 1;
          mfaddr = ref_addr(nv, 0, mdbl);
        end
        mfired = 1;
      end
      if (mh != HA) mfired = 0;
      if (pix_en) begin
        if (mh == 0 && mv == 0) mdbl = dbl;
        mhs = !(mh >= HA + HFP && mh < HA + HFP + HSW);
        mvs = !(mv >= VA + VFP && mv < VA + VFP + VSW);
        mde = (mh < HA) && (mv < VA);
        if (mde) maddr = ref_addr(mv, mh, mdbl);
        mfs = (mh == 0 && mv == 0);
        mls = (mh == 0 && mv < VA);
        if (mh == HT - 1) begin mh = 0; mv = (mv == VT - 1) ? 0 : mv + 1; end
        else mh = mh + 1;
      end
    end
    exp_q.push_back({mhs, mvs, mde, mfs, mls, mreq, mund, maddr, mfaddr});
  endtask

  initial forever begin
    @(posedge clk_int);
    model_step();
  end

  // Memory side: acknowledge one cycle after a request is seen.
  initial forever begin
    @(negedge clk_int);
    fetch_ack = ack_en && fetch_req && !fetch_ack;
  end

  // Advance one clock and fetch the matching scoreboard entry into e.
  task automatic tick();
    @(posedge clk_int);
    #1;
    cyc++;
    if (exp_q.size() == 0) e = 'x;
    else e = exp_q.pop_front();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      tick();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL reset cyc=%0d got=%b/%0d/%0d want=%b/%0d/%0d", cyc,
                 obs[2*AW+6:2*AW], obs[2*AW-1:AW], obs[AW-1:0], e[2*AW+6:2*AW], e[2*AW-1:AW], e[AW-1:0]);
      end
    end
    total++;
    if ({hs, vs, de, fetch_req, underrun, pix_addr} !== {5'b11000, AW'(BASE)}) begin
      bad++;
      $display("FAIL reset_values got=%b/%0d want=11000/%0d", {hs, vs, de, fetch_req, underrun}, pix_addr, BASE);
    end
    rst = 1'b0;
  endtask

  task automatic test_normal();
    int hs_cnt = 0, de_cnt = 0, max_addr = 0;
    dbl = 1'b0; pix_en = 1'b1; ack_en = 1'b1;
    for (int i = 0; i < 2 * FT; i++) begin
      tick();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL normal cyc=%0d got=%b/%0d/%0d want=%b/%0d/%0d", cyc,
                 obs[2*AW+6:2*AW], obs[2*AW-1:AW], obs[AW-1:0], e[2*AW+6:2*AW], e[2*AW-1:AW], e[AW-1:0]);
      end
      if (i >= FT) begin
        if (hs === 1'b0) hs_cnt++;
        if (de === 1'b1) begin
          de_cnt++;
          if (int'(pix_addr) > max_addr) max_addr = int'(pix_addr);
        end
      end
    end
    total++;
    if (hs_cnt != HSW * VT) begin bad++; $display("FAIL hs_per_frame got=%0d want=%0d", hs_cnt, HSW * VT); end
    total++;
    if (de_cnt != HA * VA) begin bad++; $display("FAIL de_per_frame got=%0d want=%0d", de_cnt, HA * VA); end
    total++;
    if (max_addr != BASE + HA * VA - 1) begin
      bad++; $display("FAIL last_pix_addr got=%0d want=%0d", max_addr, BASE + HA * VA - 1);
    end
  endtask

  task automatic test_dbl();
    int rises = 0;
    logic prev_req;
    dbl = 1'b1;
    prev_req = fetch_req;
    for (int i = 0; i < 3 * FT; i++) begin
      if (i == 2 * FT + FT / 2) dbl = 1'b0;
      tick();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL dbl cyc=%0d got=%b/%0d/%0d want=%b/%0d/%0d", cyc,
                 obs[2*AW+6:2*AW], obs[2*AW-1:AW], obs[AW-1:0], e[2*AW+6:2*AW], e[2*AW-1:AW], e[AW-1:0]);
      end
      if (i >= FT && i < 2 * FT && fetch_req === 1'b1 && prev_req === 1'b0) rises++;
      prev_req = fetch_req;
    end
    total++;
    if (rises != VA / 2) begin bad++; $display("FAIL dbl_fetch_count got=%0d want=%0d", rises, VA / 2); end
    dbl = 1'b0;
  endtask

  task automatic test_stall();
    logic en_edge;
    logic [AW+4:0] prev_pix;
    prev_pix = {hs, vs, de, frame_start, line_start, pix_addr};
    for (int i = 0; i < 2 * FT; i++) begin
      en_edge = pix_en;
      tick();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL stall cyc=%0d got=%b/%0d/%0d want=%b/%0d/%0d", cyc,
                 obs[2*AW+6:2*AW], obs[2*AW-1:AW], obs[AW-1:0], e[2*AW+6:2*AW], e[2*AW-1:AW], e[AW-1:0]);
      end
      if (!en_edge) begin
        total++;
        if ({hs, vs, de, frame_start, line_start, pix_addr} !== prev_pix) begin
          bad++;
          $display("FAIL stall_hold cyc=%0d got=%h want=%h", cyc, {hs, vs, de, frame_start, line_start, pix_addr}, prev_pix);
        end
      end
      prev_pix = {hs, vs, de, frame_start, line_start, pix_addr};
      pix_en = ~pix_en;
    end
    pix_en = 1'b1;
  endtask

  task automatic test_underrun();
    int first = -1;
    ack_en = 1'b0;
    rst = 1'b1;
    tick();
    total++;
    if (obs !== e) begin bad++; $display("FAIL underrun_rst got=%h want=%h", obs, e); end
    rst = 1'b0;
    for (int n = 1; n <= FT + HT + 10; n++) begin
      tick();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL underrun cyc=%0d got=%b/%0d/%0d want=%b/%0d/%0d", cyc,
                 obs[2*AW+6:2*AW], obs[2*AW-1:AW], obs[AW-1:0], e[2*AW+6:2*AW], e[2*AW-1:AW], e[AW-1:0]);
      end
      if (first < 0 && underrun === 1'b1) first = n;
    end
    total++;
    if (first != HT + 1) begin bad++; $display("FAIL underrun_time got=%0d want=%0d", first, HT + 1); end
    total++;
    if (underrun !== 1'b1) begin bad++; $display("FAIL underrun_sticky got=%b want=1", underrun); end
  endtask

  task automatic test_rst_mid_request();
    int n = 0;
    ack_en = 1'b0;
    while (!(mv == 3 && mh == HA + 2) && n < 2 * FT) begin
      tick();
      n++;
      total++;
      if (obs !== e) begin bad++; $display("FAIL rst_mid_run cyc=%0d got=%h want=%h", cyc, obs, e); end
    end
    total++;
    if (n >= 2 * FT) begin bad++; $display("FAIL rst_mid_timeout got=%0d cycles want<%0d", n, 2 * FT); end
    total++;
    if (fetch_req !== 1'b1) begin bad++; $display("FAIL rst_mid_req_pending got=%b want=1", fetch_req); end
    rst = 1'b1;
    tick();
    total++;
    if (obs !== e) begin bad++; $display("FAIL rst_mid_sb cyc=%0d got=%h want=%h", cyc, obs, e); end
    total++;
    if ({fetch_req, de, underrun, pix_addr} !== {3'b000, AW'(BASE)}) begin
      bad++;
      $display("FAIL rst_mid_clear got=%b/%0d want=000/%0d", {fetch_req, de, underrun}, pix_addr, BASE);
    end
    rst = 1'b0;
    ack_en = 1'b1;
    tick();
    total++;
    if (frame_start !== 1'b1 || obs !== e) begin
      bad++; $display("FAIL rst_release_frame_start got=%b/%h want=1/%h", frame_start, obs, e);
    end
    for (int i = 0; i < FT; i++) begin
      tick();
      total++;
      if (obs !== e) begin bad++; $display("FAIL rst_after cyc=%0d got=%h want=%h", cyc, obs, e); end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_dbl();
    test_stall();
    test_underrun();
    test_rst_mid_request();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
